// File: rtl/stopwatch_pkg.sv
// Shared constants, mode encodings and the binary-to-BCD split used by the
// stopwatch core and its 7-segment consumer.
package stopwatch_pkg;

    localparam int unsigned SEC_MAX_DEF = 59;
    localparam int unsigned MAX_MIN_DEF = 99;
    localparam int unsigned BCD_W       = 4;
    localparam int unsigned BIN_W       = 7;

    localparam logic ADJ_MIN = 1'b0;
    localparam logic ADJ_SEC = 1'b1;
    localparam logic DIR_UP  = 1'b0;
    localparam logic DIR_DN  = 1'b1;

    // Splits a 0..99 binary value into {tens, ones} BCD digits.
    function automatic logic [2*BCD_W-1:0] to_bcd(input logic [BIN_W-1:0] v);
        return {BCD_W'(v / BIN_W'(10)), BCD_W'(v % BIN_W'(10))};
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up/down counter over 0..MAX that wraps within itself; carry flags the
// upward wrap in the same cycle so a following field can chain on it.
module wrap_counter #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] value,
    output logic         carry
);

    always_ff @(posedge clk) begin
        if (RESET) begin
            value <= '0;
        end else if (en) begin
            if (up) begin
                value <= (value == W'(MAX)) ? '0 : value + W'(1);
            end else begin
                value <= (value == '0) ? W'(MAX) : value - W'(1);
            end
        end
    end

    assign carry = en & up & (value == W'(MAX));

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch on a single clock with tick enables, pause, lap freeze,
// configurable minute ceiling and a rollover pulse; drives BCD digits.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_MIN = MAX_MIN_DEF,
    parameter int unsigned MIN_W   = 7,
    parameter int unsigned SEC_MAX = SEC_MAX_DEF
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             count_tick,
    input  logic             adjust_tick,
    input  logic             adj,
    input  logic             sel,
    input  logic             dir,
    input  logic             pause_tog,
    input  logic             lap_tog,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             paused,
    output logic             lap_active,
    output logic             rollover
);

    localparam int unsigned SEC_W = $clog2(SEC_MAX + 1);

    logic [SEC_W-1:0] sec_val, lap_sec, disp_sec;
    logic [MIN_W-1:0] min_val, lap_min, disp_min;
    logic             sec_en, min_en, step_up;
    logic             sec_carry, min_carry;

    // Adjust steps one selected field with no carry; counting chains sec into min.
    always_comb begin
        step_up = 1'b1;
        sec_en  = 1'b0;
        min_en  = 1'b0;
        if (adj) begin
            step_up = (dir == DIR_UP);
            sec_en  = adjust_tick & (sel == ADJ_SEC);
            min_en  = adjust_tick & (sel == ADJ_MIN);
        end else begin
            sec_en  = count_tick & ~paused;
            min_en  = sec_carry;
        end
    end

    wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk   (clk),
        .RESET (RESET),
        .en    (sec_en),
        .up    (step_up),
        .value (sec_val),
        .carry (sec_carry)
    );

    wrap_counter #(.MAX(MAX_MIN), .W(MIN_W)) u_min (
        .clk   (clk),
        .RESET (RESET),
        .en    (min_en),
        .up    (step_up),
        .value (min_val),
        .carry (min_carry)
    );

    // Snapshot takes the pre-increment value when lap and a count coincide.
    always_ff @(posedge clk) begin
        if (RESET) begin
            paused     <= 1'b0;
            lap_active <= 1'b0;
            rollover   <= 1'b0;
            lap_min    <= '0;
            lap_sec    <= '0;
        end else begin
            paused   <= paused ^ pause_tog;
            rollover <= ~adj & min_carry;
            if (lap_tog) begin
                if (lap_active) begin
                    lap_active <= 1'b0;
                end else begin
                    lap_active <= 1'b1;
                    lap_min    <= min_val;
                    lap_sec    <= sec_val;
                end
            end
        end
    end

    assign disp_min = lap_active ? lap_min : min_val;
    assign disp_sec = lap_active ? lap_sec : sec_val;

    assign {min_tens, min_ones} = to_bcd(BIN_W'(disp_min));
    assign {sec_tens, sec_ones} = to_bcd(BIN_W'(disp_sec));

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: default build plus a MAX_MIN=5 build
// sharing the same stimulus.
module tb_stopwatch_core;

    logic clk = 1'b0;
    logic RESET, count_tick, adjust_tick, adj, sel, dir, pause_tog, lap_tog;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic paused, lap_active, rollover;
    logic [3:0] s_min_tens, s_min_ones, s_sec_tens, s_sec_ones;
    logic s_paused, s_lap_active, s_rollover;
    logic [15:0] digits, s_digits;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign digits   = {min_tens, min_ones, sec_tens, sec_ones};
    assign s_digits = {s_min_tens, s_min_ones, s_sec_tens, s_sec_ones};

    stopwatch_core dut (
        .clk(clk), .RESET(RESET), .count_tick(count_tick), .adjust_tick(adjust_tick),
        .adj(adj), .sel(sel), .dir(dir), .pause_tog(pause_tog), .lap_tog(lap_tog),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .paused(paused), .lap_active(lap_active), .rollover(rollover)
    );

    stopwatch_core #(.MAX_MIN(5), .MIN_W(3), .SEC_MAX(59)) dut_small (
        .clk(clk), .RESET(RESET), .count_tick(count_tick), .adjust_tick(adjust_tick),
        .adj(adj), .sel(sel), .dir(dir), .pause_tog(pause_tog), .lap_tog(lap_tog),
        .min_tens(s_min_tens), .min_ones(s_min_ones), .sec_tens(s_sec_tens),
        .sec_ones(s_sec_ones), .paused(s_paused), .lap_active(s_lap_active),
        .rollover(s_rollover)
    );

    // One clock with the given pulses held across the edge; returns #1 after it.
    task automatic step(input logic ct, input logic at, input logic pt, input logic lt);
        count_tick  = ct;
        adjust_tick = at;
        pause_tog   = pt;
        lap_tog     = lt;
        @(posedge clk);
        #1;
        count_tick  = 1'b0;
        adjust_tick = 1'b0;
        pause_tog   = 1'b0;
        lap_tog     = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        adj   = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        RESET = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        checks++;
        if (digits !== 16'h0000 || paused !== 1'b0 || lap_active !== 1'b0 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL reset: digits=%h paused=%b lap=%b roll=%b, want 0000 0 0 0",
                     digits, paused, lap_active, rollover);
        end
    endtask

    task automatic test_sec_carry();
        do_reset();
        adj = 1'b1; sel = 1'b1; dir = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        adj = 1'b0;
        checks++;
        if (digits !== 16'h0058) begin
            errors++;
            $display("FAIL preload_58: got %h want 0058", digits);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0059) begin
            errors++;
            $display("FAIL count_59: got %h want 0059", digits);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0100 || sec_tens !== 4'd0 || min_ones !== 4'd1) begin
            errors++;
            $display("FAIL carry_100: got %h want 0100", digits);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        adj = 1'b1; sel = 1'b0; dir = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        sel = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        adj = 1'b0;
        checks++;
        if (digits !== 16'h9959 || s_digits !== 16'h0559) begin
            errors++;
            $display("FAIL preload_max: got %h/%h want 9959/0559", digits, s_digits);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0000 || rollover !== 1'b1) begin
            errors++;
            $display("FAIL rollover_wrap: got %h roll=%b want 0000 1", digits, rollover);
        end
        checks++;
        if (s_digits !== 16'h0000 || s_rollover !== 1'b1) begin
            errors++;
            $display("FAIL small_rollover: got %h roll=%b want 0000 1", s_digits, s_rollover);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rollover !== 1'b0 || s_rollover !== 1'b0) begin
            errors++;
            $display("FAIL rollover_pulse: got %b/%b want 0/0", rollover, s_rollover);
        end
    endtask

    task automatic test_adjust();
        do_reset();
        adj = 1'b1; sel = 1'b0; dir = 1'b0;
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        sel = 1'b1; dir = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0359) begin
            errors++;
            $display("FAIL sec_borrow: got %h want 0359", digits);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0359) begin
            errors++;
            $display("FAIL count_in_adjust: got %h want 0359", digits);
        end
        sel = 1'b0;
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h9959) begin
            errors++;
            $display("FAIL min_down_wrap: got %h want 9959", digits);
        end
        dir = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0059 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL min_up_wrap: got %h roll=%b want 0059 0", digits, rollover);
        end
        adj = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0100) begin
            errors++;
            $display("FAIL count_beats_adjust: got %h want 0100", digits);
        end
    endtask

    task automatic test_pause();
        do_reset();
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (paused !== 1'b1 || digits !== 16'h0010) begin
            errors++;
            $display("FAIL pause_set: got %h paused=%b want 0010 1", digits, paused);
        end
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0010) begin
            errors++;
            $display("FAIL paused_hold: got %h want 0010", digits);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0011 || paused !== 1'b0) begin
            errors++;
            $display("FAIL resume: got %h paused=%b want 0011 0", digits, paused);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (digits !== 16'h0012 || paused !== 1'b1) begin
            errors++;
            $display("FAIL tick_with_pause: got %h paused=%b want 0012 1", digits, paused);
        end
        adj = 1'b1; sel = 1'b1; dir = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        adj = 1'b0;
        checks++;
        if (digits !== 16'h0013 || paused !== 1'b1) begin
            errors++;
            $display("FAIL adjust_while_paused: got %h paused=%b want 0013 1", digits, paused);
        end
    endtask

    task automatic test_lap();
        do_reset();
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0020 || lap_active !== 1'b1) begin
            errors++;
            $display("FAIL lap_freeze: got %h lap=%b want 0020 1", digits, lap_active);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (digits !== 16'h0023 || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL lap_release: got %h lap=%b want 0023 0", digits, lap_active);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0023 || lap_active !== 1'b1) begin
            errors++;
            $display("FAIL lap_pre_increment: got %h lap=%b want 0023 1", digits, lap_active);
        end
        RESET = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        checks++;
        if (digits !== 16'h0000 || lap_active !== 1'b0 || paused !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_lap: got %h lap=%b paused=%b want 0000 0 0",
                     digits, lap_active, paused);
        end
    endtask

    initial begin
        RESET = 1'b1; count_tick = 1'b0; adjust_tick = 1'b0; adj = 1'b0;
        sel = 1'b0; dir = 1'b0; pause_tog = 1'b0; lap_tog = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RESET = 1'b0;
        test_reset();
        test_sec_carry();
        test_rollover();
        test_adjust();
        test_pause();
        test_lap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
